// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size encodings, FSM states and mask helpers for mem_access_unit
package mem_access_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Expands a byte-enable mask to a 64-bit bit mask.
  function automatic logic [63:0] mask_to_bits(input logic [7:0] mask);
    logic [63:0] bits;
    for (int i = 0; i < 8; i++) begin
      bits[i*8 +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - combinational size/sign extender for load data
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] ext
);

  always_comb begin
    ext = data;
    case (size)
      SZ_B:    ext = {{56{data[7]  & ~is_unsigned}}, data[7:0]};
      SZ_H:    ext = {{48{data[15] & ~is_unsigned}}, data[15:0]};
      SZ_W:    ext = {{32{data[31] & ~is_unsigned}}, data[31:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store sequencer to the memory model
// Optional misalignment trap: MEM_ACCESS_MISALIGN_TRAP_EN
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wen,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_rd_en,
  output logic [63:0]      mem_rd_addr,
  input  logic [63:0]      mem_rd_data,
  output logic             mem_we_en,
  output logic [63:0]      mem_we_addr,
  output logic [63:0]      mem_we_data,
  output logic [7:0]       mem_we_mask,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  state_e             state_q, state_d;
  logic               wen_q, wen_d;
  logic [63:0]        addr_q, addr_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

  logic               trap;
  logic               do_rd;
  logic               do_wr;
  logic [63:0]        ext;

  mem_load_ext u_load_ext (
    .data        (mem_rd_data),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (ext)
  );

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic [2:0] low_mask;
  assign low_mask = 3'((4'd1 << size_q) - 4'd1);
  assign trap     = |(addr_q[2:0] & low_mask);
`else
  assign trap = 1'b0;
`endif

  // A trapped access still walks ACCESS/RESP but never touches memory.
  assign do_rd = (state_q == ACCESS) && !wen_q && !trap;
  assign do_wr = (state_q == ACCESS) &&  wen_q && !trap;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = 64'h0;
    mem_we_en   = 1'b0;
    mem_we_addr = 64'h0;
    mem_we_data = 64'h0;
    mem_we_mask = 8'h00;
    case (state_q)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        if (do_rd) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = addr_q;
        end
        if (do_wr) begin
          mem_we_en   = 1'b1;
          mem_we_addr = addr_q;
          mem_we_mask = size_to_mask(size_q);
          mem_we_data = wdata_q & mask_to_bits(size_to_mask(size_q));
        end
      end
      RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q + (do_rd ? CNT_W'(1) : CNT_W'(0));
    wr_cnt_d = wr_cnt_q + (do_wr ? CNT_W'(1) : CNT_W'(0));
    if (state_q == IDLE && req_valid) begin
      wen_d   = req_wen;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      size_d  = req_size;
      uns_d   = req_unsigned;
    end
    if (state_q == ACCESS) begin
      rdata_d = do_rd ? ext : 64'h0;
      err_d   = trap;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wen_q    <= 1'b0;
      addr_q   <= 64'h0;
      wdata_q  <= 64'h0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      rdata_q  <= 64'h0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_rd_en, mem_we_en;
  logic [63:0] mem_rd_addr, mem_rd_data, mem_we_addr, mem_we_data;
  logic [7:0]  mem_we_mask;
  logic [31:0] rd_cnt, wr_cnt;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem_word;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          en_count = 0;
  logic [31:0] exp_rd = 0;
  logic [31:0] exp_wr = 0;

  always #5 clock = ~clock;

  assign mem_rd_data = mem_rd_en ? mem_word : 64'h0;

  always @(negedge clock) if (mem_rd_en || mem_we_en) en_count++;

  mem_access_unit #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_we_en(mem_we_en), .mem_we_addr(mem_we_addr), .mem_we_data(mem_we_data),
    .mem_we_mask(mem_we_mask),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  function automatic logic [63:0] model_ext(input logic [63:0] d, input logic [1:0] sz, input logic uns);
    case (sz)
      2'd0:    return uns ? {56'h0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      2'd1:    return uns ? {48'h0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'd2:    return uns ? {32'h0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [7:0] model_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    return {56'h0, d[7:0]};
      2'd1:    return {48'h0, d[15:0]};
      2'd2:    return {32'h0, d[31:0]};
      default: return d;
    endcase
  endfunction

  // One full transaction; stall = cycles resp_ready is held low in RESP.
  task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] sz, input logic uns, input int stall, input string tag);
    exp_t e;
    logic trap;
    int   en_base;
    trap = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    trap = (addr & ((64'd1 << sz) - 64'd1)) != 64'd0;
`endif
    e.err   = trap;
    e.rdata = (wen || trap) ? 64'h0 : model_ext(mem_word, sz, uns);
    if (!trap) begin
      if (wen) exp_wr++; else exp_rd++;
    end
    sb.push_back(e);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = sz; req_unsigned = uns;
    req_valid  = 1'b1;
    resp_ready = (stall == 0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    tests_run++; if (mem_rd_en !== (!wen && !trap)) begin tests_failed++; $display("FAIL %s rd_en got %b want %b", tag, mem_rd_en, !wen && !trap); end
    tests_run++; if (mem_we_en !== (wen && !trap)) begin tests_failed++; $display("FAIL %s we_en got %b want %b", tag, mem_we_en, wen && !trap); end
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL %s access req_ready got %b want 0", tag, req_ready); end
    if (!wen && !trap) begin
      tests_run++; if (mem_rd_addr !== addr) begin tests_failed++; $display("FAIL %s rd_addr got %h want %h", tag, mem_rd_addr, addr); end
    end
    if (wen && !trap) begin
      tests_run++; if (mem_we_addr !== addr) begin tests_failed++; $display("FAIL %s we_addr got %h want %h", tag, mem_we_addr, addr); end
      tests_run++; if (mem_we_mask !== model_mask(sz)) begin tests_failed++; $display("FAIL %s we_mask got %h want %h", tag, mem_we_mask, model_mask(sz)); end
      tests_run++; if (mem_we_data !== model_wdata(wdata, sz)) begin tests_failed++; $display("FAIL %s we_data got %h want %h", tag, mem_we_data, model_wdata(wdata, sz)); end
    end
    @(posedge clock); #1;
    e = sb.pop_front();
    tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL %s resp_valid at T+2 got %b want 1", tag, resp_valid); end
    tests_run++; if (resp_rdata !== e.rdata) begin tests_failed++; $display("FAIL %s resp_rdata got %h want %h", tag, resp_rdata, e.rdata); end
    tests_run++; if (resp_err !== e.err) begin tests_failed++; $display("FAIL %s resp_err got %b want %b", tag, resp_err, e.err); end
    tests_run++; if (rd_cnt !== exp_rd) begin tests_failed++; $display("FAIL %s rd_cnt got %0d want %0d", tag, rd_cnt, exp_rd); end
    tests_run++; if (wr_cnt !== exp_wr) begin tests_failed++; $display("FAIL %s wr_cnt got %0d want %0d", tag, wr_cnt, exp_wr); end
    if (stall > 0) begin
      en_base   = en_count;
      req_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clock); #1;
        tests_run++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || req_ready !== 1'b0) begin
          tests_failed++; $display("FAIL %s stall%0d valid=%b rdata=%h ready=%b want 1 %h 0", tag, i, resp_valid, resp_rdata, req_ready, e.rdata);
        end
      end
      tests_run++; if (en_count !== en_base) begin tests_failed++; $display("FAIL %s stall enables got %0d want %0d", tag, en_count, en_base); end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clock); #1;
    tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL %s after handshake valid=%b ready=%b want 0 1", tag, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_wen = 1'b0; req_addr = 64'h0; req_wdata = 64'h0; req_size = 2'd0; req_unsigned = 1'b0;
    mem_word = 64'h0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset req_ready got %b want 1", req_ready); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset resp_valid got %b want 0", resp_valid); end
    tests_run++; if (resp_rdata !== 64'h0 || resp_err !== 1'b0) begin tests_failed++; $display("FAIL reset resp got %h/%b want 0/0", resp_rdata, resp_err); end
    tests_run++; if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin tests_failed++; $display("FAIL reset counters got %0d/%0d want 0/0", rd_cnt, wr_cnt); end
    tests_run++; if ({mem_rd_en, mem_we_en, mem_rd_addr, mem_we_addr, mem_we_data, mem_we_mask} !== '0) begin
      tests_failed++; $display("FAIL reset mem outputs got nonzero want 0");
    end
  endtask

  task automatic test_load_signed();
    mem_word = 64'h1234_5678_9ABC_DE80;
    issue(1'b0, 64'h8000_0003, 64'h0, 2'd0, 1'b0, 0, "load_b_signed");
    tests_run++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin tests_failed++; $display("FAIL load_b_signed held rdata got %h want ffffffffffffff80", resp_rdata); end
  endtask

  task automatic test_load_unsigned();
    issue(1'b0, 64'h8000_0003, 64'h0, 2'd0, 1'b1, 0, "load_b_unsigned");
    tests_run++; if (resp_rdata !== 64'h80) begin tests_failed++; $display("FAIL load_b_unsigned held rdata got %h want 80", resp_rdata); end
  endtask

  task automatic test_store_half();
    issue(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 2'd1, 1'b0, 0, "store_h");
  endtask

  task automatic test_stall();
    mem_word = 64'h0123_4567_F000_0001;
    issue(1'b0, 64'h8000_0020, 64'h0, 2'd2, 1'b0, 5, "stall_load_w");
  endtask

  task automatic test_back_to_back();
    logic [1:0] sz;
    for (int i = 0; i < 10; i++) begin
      sz       = 2'($urandom_range(0, 3));
      mem_word = {$urandom, $urandom};
      issue(1'($urandom_range(0, 1)), 64'h8000_0000 + 64'({$urandom_range(0, 255), 3'b000}),
            {$urandom, $urandom}, sz, 1'($urandom_range(0, 1)), 0, "back_to_back");
    end
  endtask

  task automatic test_misalign();
    mem_word = 64'h0000_0000_8765_4321;
    issue(1'b0, 64'h8000_0002, 64'h0, 2'd2, 1'b0, 0, "misalign_load_w");
  endtask

  task automatic test_reset_in_access();
    mem_word = 64'h55;
    req_wen = 1'b0; req_addr = 64'h8000_0040; req_size = 2'd3; req_unsigned = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    tests_run++; if (mem_rd_en !== 1'b1) begin tests_failed++; $display("FAIL rst_access rd_en got %b want 1", mem_rd_en); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0;
    tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_access valid=%b ready=%b want 0 1", resp_valid, req_ready); end
    tests_run++; if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin tests_failed++; $display("FAIL rst_access counters got %0d/%0d want 0/0", rd_cnt, wr_cnt); end
    @(posedge clock); #1;
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_access late resp_valid got %b want 0", resp_valid); end
  endtask

  task automatic test_reset_in_resp();
    issue(1'b1, 64'h8000_0080, 64'hAA, 2'd0, 1'b0, 0, "pre_rst_store");
    req_wen = 1'b0; req_addr = 64'h8000_0088; req_size = 2'd3;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_resp pre valid got %b want 1", resp_valid); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0;
    tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_resp valid=%b ready=%b want 0 1", resp_valid, req_ready); end
    tests_run++; if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin tests_failed++; $display("FAIL rst_resp counters got %0d/%0d want 0/0", rd_cnt, wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_signed();
    test_load_unsigned();
    test_store_half();
    test_stall();
    test_back_to_back();
    test_misalign();
    test_reset_in_access();
    test_reset_in_resp();
    mem_word = 64'hFFFF_FFFF_FFFF_8001;
    issue(1'b0, 64'h8000_0100, 64'h0, 2'd1, 1'b0, 0, "post_reset_load_h");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access sequencer between the pipeline memory stage and the DPI-C physical-memory model. Accepts one load or store request at a time over a valid/ready handshake. Drives the memory model's read or write port for exactly one cycle, then returns size-extended load data (or a store acknowledgement) over a valid/ready response channel. Also keeps read/write access counters for the simulation environment.

## Interface
Parameters:
- CNT_W, 32, width of each access counter

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_wdata  in  64  store data; the low bytes are significant
- req_size  in  2  0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B
- req_unsigned  in  1  load is zero-extended; ignored for size 3 and for stores
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  64  extended load data; 0 for stores
- resp_err  out  1  access rejected (see Configuration)
- mem_rd_en  out  1  memory read enable
- mem_rd_addr  out  64  memory read address
- mem_rd_data  in  64  memory read data, combinational from mem_rd_addr
- mem_we_en  out  1  memory write enable
- mem_we_addr  out  64  memory write address
- mem_we_data  out  64  memory write data
- mem_we_mask  out  8  write mask: 8'h01, 8'h03, 8'h0F or 8'hFF only
- rd_cnt  out  CNT_W  number of completed memory reads
- wr_cnt  out  CNT_W  number of completed memory writes

## Operation
The FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, register wen, addr, wdata, size and unsigned, then go to ACCESS.
- ACCESS:
  - Lasts exactly one cycle.
  - Load:
    - mem_rd_en = 1 and mem_rd_addr = the registered address.
    - mem_rd_data is extended and captured into the response register.
  - Store:
    - mem_we_en = 1 and mem_we_addr = the registered address.
    - mem_we_data = wdata with the bytes above size zeroed.
    - mem_we_mask is derived from size.
  - Go to RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable.
  - Go to IDLE when resp_ready is high.
- Outside ACCESS:
  - mem_rd_en = 0, mem_we_en = 0.
  - mem_rd_addr, mem_we_addr, mem_we_data and mem_we_mask are all 0.
  - These fixed values keep the combinational DPI reads and writes from firing spuriously.
- Load extension:
  - The result is taken from mem_rd_data[8·2^size−1:0].
  - The top bit is replicated unless req_unsigned is set; size 3 is passed through unchanged.
- Counters:
  - rd_cnt increments at the end of a load ACCESS cycle; wr_cnt increments at the end of a store ACCESS cycle.
  - Both wrap modulo 2^CNT_W.
- A request arriving while the unit is not in IDLE is not accepted; req_ready = 0 and the requester holds the request.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, rd_cnt 0, wr_cnt 0, all mem_* outputs 0.
- Request handshake at edge T:
  - cycle T+1 is ACCESS;
  - cycle T+2 is the first resp_valid cycle.
- Minimum request-to-request interval: 3 cycles. The next request is accepted in the IDLE cycle that follows the response handshake.
- resp_ready may be held high ahead of time; the response is still presented for at least one cycle.
- Reset while in ACCESS: that cycle's memory enable is already asserted and the access completes in the model. The FSM returns to IDLE, the counters clear, and no response is produced.
- Reset while in RESP: the pending response is dropped.

## Configuration
Macro MEM_ACCESS_MISALIGN_TRAP_EN:
- Defined: an access with addr mod 2^size ≠ 0 performs no memory access and no counter update. It still passes through ACCESS and RESP with the same latency, with resp_err = 1 and resp_rdata = 0.
- Undefined: misaligned addresses are passed to memory unchanged, and resp_err is tied to 0.

## Structure
- Package mem_access_pkg contains:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - the state enum IDLE, ACCESS, RESP;
  - a size-to-mask function returning 8'h01, 8'h03, 8'h0F or 8'hFF.
- Sub-module mem_load_ext: a combinational size/sign extender with inputs data, size and unsigned and output ext.

## Test plan
- Load byte, addr 0x8000_0003, memory returns 0x...0000_0080, signed → resp_rdata 0xFFFF_FFFF_FFFF_FF80 at T+2; rd_cnt = 1.
- Same load with req_unsigned = 1 → resp_rdata 0x0000_0000_0000_0080.
- Store half, addr 0x8000_0010, wdata 0x1122_3344_5566_7788 → a single ACCESS cycle with mem_we_mask 8'h03 and mem_we_data 0x7788; wr_cnt = 1; resp_rdata 0.
- resp_ready held low for 5 cycles → resp_valid and resp_rdata stay stable, req_ready stays 0, and there is no second memory enable.
- Reset asserted during RESP → the next cycle shows resp_valid 0, req_ready 1 and both counters 0.
- With MEM_ACCESS_MISALIGN_TRAP_EN: a word load at 0x8000_0002 → no mem_rd_en, resp_err 1 at T+2, rd_cnt unchanged.
